// File: rtl/slice_controller_p.sv
// Slicer job controller: ranges the workpiece, steps the feed motor, fires the cutter
// slice_num times at a fixed pitch, then reverses to the home distance and pulses finish.
module slice_controller_p #(
   parameter int DIST_W     = 17,
   parameter int SLICE_W    = 5,
   parameter int ECHO_TO    = 50000,
   parameter int MAX_RETRY  = 3,
   parameter int SETTLE_CYC = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause,
   input  logic               abort,
   input  logic [SLICE_W-1:0] slice_num,
   input  logic [DIST_W-1:0]  thickness,
   output logic               trigger,
   input  logic               triggerSuc,
   input  logic               valid,
   input  logic [DIST_W-1:0]  distance,
   output logic               move,
   output logic               back,
   output logic               cut,
   input  logic               cut_end,
   output logic               finish,
   output logic               error,
   output logic               busy,
   output logic [SLICE_W-1:0] slices_done
);

   localparam int TO_W = $clog2(ECHO_TO + 1);
   localparam int ST_W = $clog2(SETTLE_CYC + 1);
   localparam int RT_W = $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, DECIDE, STEP, CUT, DONE, ERR} state_t;

   state_t             state;
   logic               rev, first, paused, fin_pend;
   logic [SLICE_W-1:0] num_q;
   logic [DIST_W-1:0]  thk_q, home, target, dist_q;
   logic [TO_W-1:0]    to_cnt;
   logic [ST_W-1:0]    st_cnt;
   logic [RT_W-1:0]    retry;
   logic               active, paused_nx;

   function automatic logic [DIST_W-1:0] sat_sub(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
      return (a > b) ? a - b : '0;
   endfunction

   assign active    = (state != IDLE) && (state != DONE) && (state != ERR);
   assign busy      = active;
   // Drives are computed from the pause state that takes effect this edge, so a
   // pause pulse silences the motor/trigger on the very next cycle.
   assign paused_nx = (active && pause) ? ~paused : paused;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE; rev <= 1'b0; first <= 1'b0; paused <= 1'b0; fin_pend <= 1'b0;
         num_q <= '0; thk_q <= '0; home <= '0; target <= '0; dist_q <= '0;
         to_cnt <= '0; st_cnt <= '0; retry <= '0;
         trigger <= 1'b0; move <= 1'b0; back <= 1'b0; cut <= 1'b0;
         finish <= 1'b0; error <= 1'b0; slices_done <= '0;
      end else if (abort) begin
         state <= IDLE; paused <= 1'b0; fin_pend <= 1'b0; retry <= '0;
         trigger <= 1'b0; move <= 1'b0; back <= 1'b0; cut <= 1'b0;
         finish <= 1'b0; error <= 1'b0;
      end else begin
         paused <= paused_nx;
         finish <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (state == DONE && fin_pend) begin
                  finish   <= 1'b1;
                  fin_pend <= 1'b0;
               end
               if (start) begin
                  num_q <= slice_num; thk_q <= thickness; slices_done <= '0;
                  error <= 1'b0; rev <= 1'b0; first <= 1'b1; retry <= '0; paused <= 1'b0;
                  if (slice_num == '0) begin
                     state    <= DONE;
                     fin_pend <= 1'b1;
                  end else begin
                     state   <= TRIG;
                     trigger <= 1'b1;
                  end
               end
            end
            TRIG: begin
               if (triggerSuc) begin
                  trigger <= 1'b0;
                  to_cnt  <= '0;
                  state   <= WAIT_ECHO;
               end else begin
                  trigger <= ~paused_nx;
               end
            end
            WAIT_ECHO: begin
               if (valid) begin
                  dist_q <= distance;
                  retry  <= '0;
                  state  <= DECIDE;
               end else if (!paused) begin
                  if (to_cnt == TO_W'(ECHO_TO - 1)) begin
                     if (retry == RT_W'(MAX_RETRY)) begin
                        state <= ERR;
                        error <= 1'b1;
                     end else begin
                        retry   <= retry + RT_W'(1);
                        state   <= TRIG;
                        trigger <= ~paused_nx;
                     end
                  end else begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
               end
            end
            DECIDE: begin
               if (rev && dist_q >= home) begin
                  state    <= DONE;
                  fin_pend <= 1'b1;
               end else if (!rev && !first && dist_q <= target) begin
                  state <= CUT;
                  cut   <= 1'b1;
               end else begin
                  if (!rev && first) begin
                     home   <= dist_q;
                     target <= sat_sub(dist_q, thk_q);
                     first  <= 1'b0;
                  end
                  state  <= STEP;
                  st_cnt <= '0;
                  move   <= ~rev & ~paused_nx;
                  back   <= rev & ~paused_nx;
               end
            end
            STEP: begin
               // st_cnt counts cycles the motor was actually driven.
               if ((move || back) && st_cnt == ST_W'(SETTLE_CYC - 1)) begin
                  move    <= 1'b0;
                  back    <= 1'b0;
                  state   <= TRIG;
                  trigger <= ~paused_nx;
               end else begin
                  if (move || back) st_cnt <= st_cnt + ST_W'(1);
                  move <= ~rev & ~paused_nx;
                  back <= rev & ~paused_nx;
               end
            end
            CUT: begin
               if (cut_end) begin
                  cut         <= 1'b0;
                  slices_done <= slices_done + SLICE_W'(1);
                  target      <= sat_sub(target, thk_q);
                  if (slices_done + SLICE_W'(1) == num_q) rev <= 1'b1;
                  state   <= TRIG;
                  trigger <= ~paused_nx;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_slice_controller_p.sv
// Directed bench for slice_controller_p: a scripted sensor/cutter answers each ranging
// request and every observed action is compared with hand-derived expectations.
module tb_slice_controller_p;

   localparam int DW = 17, SW = 5, ETO = 40, MR = 3, SC = 16;
   localparam int A_NONE = 0, A_S = 1, A_B = 2, A_C = 3, A_D = 4;

   logic clk = 1'b0, rst = 1'b1;
   logic start = 0, pause = 0, abort = 0, triggerSuc = 0, valid = 0, cut_end = 0;
   logic [SW-1:0] slice_num = '0;
   logic [DW-1:0] thickness = '0, distance = '0;
   logic trigger, move, back, cut, finish, error, busy;
   logic [SW-1:0] slices_done;

   int checks = 0, errors = 0;
   int excl_bad = 0, trig_rises = 0;
   logic trig_q = 1'b0;

   slice_controller_p #(.DIST_W(DW), .SLICE_W(SW), .ECHO_TO(ETO), .MAX_RETRY(MR), .SETTLE_CYC(SC)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
      .slice_num(slice_num), .thickness(thickness), .trigger(trigger), .triggerSuc(triggerSuc),
      .valid(valid), .distance(distance), .move(move), .back(back), .cut(cut), .cut_end(cut_end),
      .finish(finish), .error(error), .busy(busy), .slices_done(slices_done));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (int'(trigger) + int'(move) + int'(back) + int'(cut) > 1) excl_bad++;
      if (trigger && !trig_q) trig_rises++;
      trig_q = trigger;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic go(input int n, input int t);
      slice_num = SW'(n); thickness = DW'(t); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_trig(input string tag);
      int i;
      for (i = 0; i < 60 && !trigger; i++) tick();
      chk(tag, trigger, 1);
   endtask

   // One ranging round: answer trigger, return the action taken, serve it.
   task automatic range(input int d, input int pause_at, input bit serve_cut,
                        output int act, output int mv);
      bit pdone = 0;
      act = A_NONE; mv = 0;
      wait_trig("trig_seen");
      triggerSuc = 1'b1; tick(); triggerSuc = 1'b0;
      tick();
      valid = 1'b1; distance = DW'(d); tick(); valid = 1'b0;
      tick();
      if (cut) act = A_C;
      else if (move) act = A_S;
      else if (back) act = A_B;
      else begin
         tick();
         if (finish) act = A_D;
      end
      if (act == A_C && serve_cut) begin
         tick(); tick();
         cut_end = 1'b1; tick(); cut_end = 1'b0;
      end else if (act == A_S || act == A_B) begin
         for (int i = 0; i < 200; i++) begin
            if (move || back) mv++;
            else if (trigger) break;
            if (pause_at != 0 && mv == pause_at && !pdone) begin
               pdone = 1;
               pause = 1'b1; tick(); pause = 1'b0;
               chk("pause_drop", move, 0);
               repeat (4) tick();
               chk("pause_hold", move, 0);
               pause = 1'b1; tick(); pause = 1'b0;
               chk("pause_resume", move, 1);
            end else begin
               tick();
            end
         end
      end
   endtask

   int t1_d[10]   = '{900, 850, 790, 760, 640, 610, 455, 350, 500, 910};
   int t1_act[10] = '{A_S, A_S, A_C, A_S, A_C, A_S, A_C, A_C, A_B, A_D};

   initial begin
      int act, mv, r0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_outs", {trigger, move, back, cut, finish, error, busy}, 0);
      chk("rst_sd", slices_done, 0);

      // 1: full four-slice job
      go(4, 100);
      chk("t1_busy", busy, 1);
      for (int k = 0; k < 10; k++) begin
         range(t1_d[k], 0, 1, act, mv);
         chk($sformatf("t1_act%0d", k), act, t1_act[k]);
         if (act == A_S || act == A_B) chk($sformatf("t1_mv%0d", k), mv, SC);
      end
      chk("t1_sd", slices_done, 4);
      chk("t1_idle", busy, 0);
      tick();
      chk("t1_fin_one", finish, 0);

      // 2: zero slices
      r0 = trig_rises;
      go(0, 100);
      chk("t2_fin_c1", finish, 0);
      chk("t2_busy_c1", busy, 0);
      tick();
      chk("t2_fin_c2", finish, 1);
      tick();
      chk("t2_fin_c3", finish, 0);
      chk("t2_no_trig", trig_rises - r0, 0);

      // 3: echo timeouts escalate to error
      r0 = trig_rises;
      go(1, 100);
      for (int k = 0; k < 4; k++) begin
         wait_trig("t3_trig");
         triggerSuc = 1'b1; tick(); triggerSuc = 1'b0;
         for (int i = 0; i < ETO + 10 && !trigger && !error; i++) tick();
      end
      chk("t3_error", error, 1);
      chk("t3_busy", busy, 0);
      chk("t3_trigs", trig_rises - r0, 4);
      go(0, 0);
      chk("t3_clear", error, 0);
      repeat (3) tick();

      // 4+5: pause mid-step, then abort while cutting
      go(1, 100);
      range(900, SC / 2, 0, act, mv);
      chk("t4_act", act, A_S);
      chk("t4_mv", mv, SC);
      range(850, 0, 0, act, mv);
      chk("t5_act_s", act, A_S);
      range(790, 0, 0, act, mv);
      chk("t5_act_c", act, A_C);
      chk("t5_cut_hi", cut, 1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t5_cut_lo", cut, 0);
      chk("t5_busy", busy, 0);
      cut_end = 1'b1; tick(); cut_end = 1'b0;
      tick();
      chk("t5_ignored", {trigger, move, back, cut, finish, busy}, 0);
      chk("t5_sd", slices_done, 0);

      // 6: stray strobes in IDLE, then saturated target
      valid = 1'b1; cut_end = 1'b1; triggerSuc = 1'b1; distance = 17'd5;
      tick();
      valid = 1'b0; cut_end = 1'b0; triggerSuc = 1'b0;
      tick();
      chk("t6_stray", {trigger, move, back, cut, finish, error, busy}, 0);
      go(1, 700);
      range(500, 0, 1, act, mv);
      chk("t6_home", act, A_S);
      range(300, 0, 1, act, mv);
      chk("t6_no_cut", act, A_S);
      range(0, 0, 1, act, mv);
      chk("t6_cut0", act, A_C);
      chk("t6_sd", slices_done, 1);
      range(600, 0, 1, act, mv);
      chk("t6_done", act, A_D);

      chk("excl", excl_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
